instruction_encoder: RTL and testbench

Packs decoded RISC-V fields (format, opcode, funct3, register numbers, 64-bit signed immediate) into a 32-bit I/S/SB-type instruction word. It is the inverse of `immediate_data_generator`. It validates that the immediate is representable and that the opcode is consistent with the format, then emits the word with its byte address through a one-deep registered valid/ready stage. Its output feeds instruction-memory preload and round-trip checks against the decode path.

---
 rtl/instruction_encoder.sv | 120 ++++++++++++
 tb/tb_instruction_encoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs decoded I/S/SB fields into a 32-bit RISC-V word,
// rejects unrepresentable bundles, and emits legal words with their byte address
// through a one-deep registered valid/ready stage.
module instruction_encoder #(
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [63:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_addr,
  output logic        err,
  output logic [15:0] err_count
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e      state_q, state_d;
  logic [31:0] inst_q;
  logic [63:0] addr_q;
  logic [63:0] next_addr_q;
  logic        err_q;
  logic [15:0] err_count_q;

  logic        legal;
  logic [31:0] packed_inst;
  logic        imm12_ok;
  logic        imm13_ok;
  logic        accept;
  logic        load;
  logic        reject;

  // Immediate fits when every bit above the sign bit equals the sign bit.
  assign imm12_ok = (&imm[63:11]) | ~(|imm[63:11]);
  assign imm13_ok = (&imm[63:12]) | ~(|imm[63:12]);

  // Format decode: legality check and field packing.
  always_comb begin
    legal       = 1'b0;
    packed_inst = 32'h0;
    unique case (fmt)
      2'd0: begin
        legal       = !opcode[6] && !opcode[5] && imm12_ok;
        packed_inst = {imm[11:0], rs1, funct3, rd, opcode};
      end
      2'd1: begin
        legal       = !opcode[6] && opcode[5] && imm12_ok;
        packed_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      2'd2: begin
        legal       = opcode[6] && imm13_ok && !imm[0];
        packed_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      default: begin
        legal       = 1'b0;
        packed_inst = 32'h0;
      end
    endcase
  end

  // Handshake: ready depends only on the output stage, never on in_valid.
  assign in_ready = (state_q == StEmpty) || out_ready;
  assign accept   = in_valid && in_ready;
  assign load     = accept && legal;
  assign reject   = accept && !legal;

  // Output stage next state: fill on legal accept, empty on drain without refill.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (load) state_d = StFull;
      StFull:  if (out_ready && !load) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StEmpty;
    else       state_q <= state_d;
  end

  // Output word, address counter and sticky error bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q      <= 32'h0;
      addr_q      <= BASE_ADDR;
      next_addr_q <= BASE_ADDR;
      err_q       <= 1'b0;
      err_count_q <= 16'h0;
    end else begin
      if (load) begin
        inst_q      <= packed_inst;
        addr_q      <= next_addr_q;
        next_addr_q <= next_addr_q + 64'd4;
      end
      if (reject) begin
        err_q <= 1'b1;
        if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
      end
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_inst  = inst_q;
  assign out_addr  = addr_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed self-checking bench for instruction_encoder.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [1:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [63:0] imm, out_addr;
  logic [31:0] out_inst;
  logic [15:0] err_count;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_err;
  logic [63:0] w_out_addr;
  logic [31:0] w_out_inst;
  logic [15:0] w_err_count;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  instruction_encoder #(.BASE_ADDR(64'h0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .err(err), .err_count(err_count)
  );

  instruction_encoder #(.BASE_ADDR(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .out_valid(w_out_valid), .out_ready(w_out_ready), .out_inst(w_out_inst),
    .out_addr(w_out_addr), .err(w_err), .err_count(w_err_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                            input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                            input logic [63:0] im);
    fmt = f; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Reference immediate extraction, as the decode path sees the word.
  function automatic logic [63:0] decode_imm(input logic [1:0] f, input logic [31:0] w);
    logic [11:0] v;
    case (f)
      2'd0:    v = w[31:20];
      2'd1:    v = {w[31:25], w[11:7]};
      default: v = {w[31], w[7], w[30:25], w[11:8]};
    endcase
    return {{52{v[11]}}, v};
  endfunction

  logic [1:0]  bad_fmt [4] = '{2'd0, 2'd2, 2'd3, 2'd0};
  logic [6:0]  bad_op  [4] = '{7'h13, 7'h63, 7'h13, 7'h23};
  logic [63:0] bad_imm [4] = '{64'd2048, 64'd3, 64'd0, 64'd0};

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_out_ready = 1'b1;
    set_fields(2'd0, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0);
    #1;
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset out_inst", {32'd0, out_inst}, 64'd0);
    check("reset out_addr", out_addr, 64'd0);
    check("reset err", {63'd0, err}, 64'd0);
    check("reset err_count", {48'd0, err_count}, 64'd0);
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    step(); step();
    reset = 1'b0;

    // I-type, imm = -1
    set_fields(2'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, -64'sd1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("I valid", {63'd0, out_valid}, 64'd1);
    check("I inst", {32'd0, out_inst}, 64'hFFF30293);
    check("I addr", out_addr, 64'h0);
    check("I roundtrip", decode_imm(2'd0, out_inst), -64'sd1);

    // S then SB back-to-back
    do_reset();
    set_fields(2'd1, 7'h23, 3'd3, 5'd0, 5'd1, 5'd2, 64'd8);
    in_valid = 1'b1;
    step();
    check("S inst", {32'd0, out_inst}, 64'h0020B423);
    check("S addr", out_addr, 64'h0);
    check("S roundtrip", decode_imm(2'd1, out_inst), 64'd8);
    set_fields(2'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, -64'sd8);
    step();
    in_valid = 1'b0;
    check("SB inst", {32'd0, out_inst}, 64'hFE208CE3);
    check("SB addr", out_addr, 64'h4);
    check("SB roundtrip", decode_imm(2'd2, out_inst), -64'sd4);
    step();
    check("drain empties", {63'd0, out_valid}, 64'd0);

    // Illegal bundles after one legal word at address 0
    do_reset();
    set_fields(2'd0, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 64'd5);
    in_valid = 1'b1;
    step();
    check("pre-illegal addr", out_addr, 64'h0);
    for (int i = 0; i < 4; i++) begin
      set_fields(bad_fmt[i], bad_op[i], 3'd0, 5'd1, 5'd2, 5'd3, bad_imm[i]);
      step();
      check($sformatf("illegal%0d out_valid", i), {63'd0, out_valid}, 64'd0);
      check($sformatf("illegal%0d err_count", i), {48'd0, err_count}, 64'(i + 1));
    end
    set_fields(2'd0, 7'h03, 3'd2, 5'd7, 5'd8, 5'd0, 64'd2047);
    step();
    in_valid = 1'b0;
    check("post-illegal valid", {63'd0, out_valid}, 64'd1);
    check("post-illegal addr", out_addr, 64'h4);
    check("post-illegal inst", {32'd0, out_inst}, 64'h7FF42383);
    check("err sticky", {63'd0, err}, 64'd1);
    check("err_count 4", {48'd0, err_count}, 64'd4);

    // Backpressure: A held, B waits
    do_reset();
    out_ready = 1'b0;
    set_fields(2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd1);
    in_valid = 1'b1;
    step();
    check("A inst", {32'd0, out_inst}, 64'h00100093);
    set_fields(2'd0, 7'h13, 3'd0, 5'd2, 5'd0, 5'd0, 64'd2);
    for (int i = 0; i < 5; i++) begin
      check("bp in_ready", {63'd0, in_ready}, 64'd0);
      check("bp inst held", {32'd0, out_inst}, 64'h00100093);
      check("bp addr held", out_addr, 64'h0);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("B inst", {32'd0, out_inst}, 64'h00200113);
    check("B addr", out_addr, 64'h4);
    check("B valid", {63'd0, out_valid}, 64'd1);

    // Reset mid-cycle while FULL with an error recorded
    do_reset();
    set_fields(2'd3, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd0);
    in_valid = 1'b1;
    step();
    out_ready = 1'b0;
    set_fields(2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd1);
    step();
    in_valid = 1'b0;
    check("pre-reset full", {63'd0, out_valid}, 64'd1);
    check("pre-reset err_count", {48'd0, err_count}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async out_valid", {63'd0, out_valid}, 64'd0);
    check("async err", {63'd0, err}, 64'd0);
    check("async err_count", {48'd0, err_count}, 64'd0);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("post-reset addr", out_addr, 64'h0);

    // Address wrap and error-count saturation on the high-base instance
    do_reset();
    set_fields(2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd1);
    w_in_valid = 1'b1;
    step();
    check("wrap addr0", w_out_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    check("wrap addr1", w_out_addr, 64'h0);
    set_fields(2'd3, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd0);
    for (int i = 0; i < 65534; i++) step();
    check("sat FFFE", {48'd0, w_err_count}, 64'hFFFE);
    step();
    check("sat FFFF", {48'd0, w_err_count}, 64'hFFFF);
    step();
    w_in_valid = 1'b0;
    check("sat hold", {48'd0, w_err_count}, 64'hFFFF);
    check("sat err", {63'd0, w_err}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
